// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: fetch FSM state encoding, reset vector and address helpers.
package pc_fetch_unit_pkg;
   typedef enum logic [1:0] {FS_REQ, FS_WAIT, FS_DROP, FS_HOLD} fetch_state_e;
   localparam logic [31:0] RESET_VECTOR = 32'h0000_3000;
   function automatic logic [31:0] align_word(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: redirect, instruction-memory and decode handshake signals of the fetch stage.
interface pc_fetch_unit_if;
   logic [31:0] npc;
   logic        redirect;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   modport master (
      input  npc, redirect, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
      output imem_req, imem_addr, inst_valid, inst, inst_pc
   );
   modport slave (
      output npc, redirect, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
      input  imem_req, imem_addr, inst_valid, inst, inst_pc
   );
endinterface

// File: rtl/pc_fetch_unit_fetch_queue.sv
// pc_fetch_unit_fetch_queue: {pc, inst} FIFO; flush wins over push and pop.
module pc_fetch_unit_fetch_queue #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [31:0]                i_pc,
   input  logic [31:0]                i_inst,
   input  logic                       i_pop,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic [31:0]                o_pc,
   output logic [31:0]                o_inst
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [31:0]   r_pc   [DEPTH];
   logic [31:0]   r_inst [DEPTH];
   logic [AW-1:0] r_wr, r_rd;
   logic [CW-1:0] r_count;
   logic          w_pop, w_push;
   assign w_pop   = i_pop && r_count != '0;
   assign w_push  = i_push && (r_count != CW'(DEPTH) || w_pop);
   assign o_count = r_count;
   assign o_pc    = r_pc[r_rd];
   assign o_inst  = r_inst[r_rd];
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_pc[i]   <= RESET_PC;
            r_inst[i] <= '0;
         end
      end else if (i_flush) begin
         r_rd    <= r_wr;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_pc[r_wr]   <= i_pc;
            r_inst[r_wr] <= i_inst;
            r_wr         <= r_wr + 1'b1;
         end
         if (w_pop) r_rd <= r_rd + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the fetch PC, issues one outstanding imem fetch at a time and queues words for decode.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_VECTOR,
   parameter int          IQ_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   pc_fetch_unit_if.master  bus
);
   localparam int CW = $clog2(IQ_DEPTH) + 1;
   fetch_state_e  r_state;
   logic [31:0]   r_fpc, r_req_pc;
   logic          r_run;
   logic [CW-1:0] w_count;
   logic [31:0]   w_head_pc, w_head_inst;
   logic          w_req, w_gnt, w_push, w_pop, w_busy;
   // r_run keeps imem_req low for the first cycle after reset releases
   assign w_req  = r_run && r_state == FS_REQ;
   assign w_gnt  = w_req && bus.imem_gnt;
   assign w_push = r_state == FS_WAIT && bus.imem_rvalid && !bus.redirect;
   assign w_pop  = bus.inst_valid && bus.inst_ready;
   assign w_busy = (r_state == FS_WAIT || r_state == FS_DROP) && !bus.imem_rvalid;
   assign bus.imem_req   = w_req;
   assign bus.imem_addr  = r_fpc;
   assign bus.inst_valid = w_count != '0;
   assign bus.inst       = w_head_inst;
   assign bus.inst_pc    = w_head_pc;
   pc_fetch_unit_fetch_queue #(.DEPTH(IQ_DEPTH), .RESET_PC(RESET_PC)) u_fetch_queue (
      .clk     (clk),
      .rst     (rst),
      .i_flush (bus.redirect),
      .i_push  (w_push),
      .i_pc    (r_req_pc),
      .i_inst  (bus.imem_rdata),
      .i_pop   (w_pop),
      .o_count (w_count),
      .o_pc    (w_head_pc),
      .o_inst  (w_head_inst)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= FS_REQ;
         r_fpc    <= RESET_PC;
         r_req_pc <= RESET_PC;
         r_run    <= 1'b0;
      end else begin
         r_run <= 1'b1;
         if (bus.redirect) begin
            r_fpc   <= align_word(bus.npc);
            r_state <= (w_busy || w_gnt) ? FS_DROP : FS_REQ;
         end else begin
            case (r_state)
               FS_REQ: if (w_gnt) begin
                  r_req_pc <= r_fpc;
                  r_fpc    <= r_fpc + 32'd4;
                  r_state  <= FS_WAIT;
               end
               FS_WAIT: if (bus.imem_rvalid)
                  r_state <= (w_count == CW'(IQ_DEPTH - 1) && !w_pop) ? FS_HOLD : FS_REQ;
               FS_DROP: if (bus.imem_rvalid) r_state <= FS_REQ;
               default: if (w_count < CW'(IQ_DEPTH)) r_state <= FS_REQ;
            endcase
         end
      end
   end
endmodule
